// File: rtl/pwm_ramp_sequencer_if.sv
// rtl/pwm_ramp_sequencer_if.sv - control/config and PWM-drive bundle of the ramp sequencer
interface pwm_ramp_sequencer_if #(
    parameter int W       = 16,
    parameter int DWELL_W = 8
);
    logic               start;
    logic               abort;
    logic [W-1:0]       period_in;
    logic [W-1:0]       dc_target;
    logic [W-1:0]       dc_step;
    logic [DWELL_W-1:0] dwell;
    logic [W-1:0]       counter;
    logic [W-1:0]       period_reg;
    logic [W-1:0]       DC_reg;
    logic               pwm_en;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, period_in, dc_target, dc_step, dwell, counter,
        input  period_reg, DC_reg, pwm_en, busy, done
    );

    modport slave (
        input  start, abort, period_in, dc_target, dc_step, dwell, counter,
        output period_reg, DC_reg, pwm_en, busy, done
    );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// rtl/pwm_ramp_sequencer.sv - soft-start duty-cycle ramp, updates only at PWM period boundaries
module pwm_ramp_sequencer #(
    parameter int W       = 16,
    parameter int DWELL_W = 8
) (
    input  logic                 chosen_clk,
    input  logic                 rst,
    pwm_ramp_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RAMP, S_HOLD} state_t;

    state_t             r_state, w_state_nxt;
    logic [W-1:0]       r_counter_q;
    logic [W-1:0]       r_period_reg, w_period_nxt;
    logic [W-1:0]       r_dc_reg, w_dc_nxt;
    logic               r_pwm_en, w_pwm_en_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [W-1:0]       r_tgt, w_tgt_nxt;
    logic [W-1:0]       r_stp, w_stp_nxt;
    logic [DWELL_W-1:0] r_dw, w_dw_nxt;
    logic [W-1:0]       r_per, w_per_nxt;
    logic               r_arm, w_arm_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_cnt_nxt;

    logic               w_wrap;
    logic [W-1:0]       w_new_tgt;
    logic [DWELL_W-1:0] w_new_dw;
    logic [W:0]         w_sum;
    logic [W:0]         w_diff;
    logic [W-1:0]       w_step;

    assign w_wrap    = (bus.counter == '0) && (r_counter_q != '0);
    assign w_new_tgt = (bus.dc_target < bus.period_in) ? bus.dc_target : bus.period_in;
    assign w_new_dw  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign w_sum     = {1'b0, r_dc_reg} + {1'b0, r_stp};
    assign w_diff    = {1'b0, r_dc_reg} - {1'b0, r_stp};

    // Saturating step toward target; a borrow out of the difference clamps to target
    always_comb begin
        w_step = r_tgt;
        if (r_stp != '0) begin
            if (r_tgt >= r_dc_reg) begin
                w_step = (w_sum > {1'b0, r_tgt}) ? r_tgt : w_sum[W-1:0];
            end else begin
                w_step = (w_diff[W] || (w_diff[W-1:0] < r_tgt)) ? r_tgt : w_diff[W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_period_nxt    = r_period_reg;
        w_dc_nxt        = r_dc_reg;
        w_pwm_en_nxt    = r_pwm_en;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_tgt_nxt       = r_tgt;
        w_stp_nxt       = r_stp;
        w_dw_nxt        = r_dw;
        w_per_nxt       = r_per;
        w_arm_nxt       = r_arm;
        w_dwell_cnt_nxt = r_dwell_cnt;
        case (r_state)
            S_IDLE: begin
                w_pwm_en_nxt = 1'b0;
                if (bus.start) begin
                    w_tgt_nxt       = w_new_tgt;
                    w_stp_nxt       = bus.dc_step;
                    w_dw_nxt        = w_new_dw;
                    w_per_nxt       = bus.period_in;
                    w_period_nxt    = bus.period_in;
                    w_dc_nxt        = '0;
                    w_pwm_en_nxt    = 1'b1;
                    w_dwell_cnt_nxt = '0;
                    w_arm_nxt       = 1'b0;
                    if (w_new_tgt == '0) begin
                        w_state_nxt = S_HOLD;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RAMP;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            S_RAMP: begin
                if (w_wrap) begin
                    // A re-start from HOLD waits one wrap to swap the period, then counts dwell
                    if (r_arm) begin
                        w_arm_nxt       = 1'b0;
                        w_period_nxt    = r_per;
                        w_dwell_cnt_nxt = '0;
                    end else if (r_dwell_cnt == (r_dw - DWELL_W'(1))) begin
                        w_dwell_cnt_nxt = '0;
                        w_dc_nxt        = w_step;
                        if (w_step == r_tgt) begin
                            w_state_nxt = S_HOLD;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_dwell_cnt_nxt = r_dwell_cnt + DWELL_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (bus.start) begin
                    w_tgt_nxt       = w_new_tgt;
                    w_stp_nxt       = bus.dc_step;
                    w_dw_nxt        = w_new_dw;
                    w_per_nxt       = bus.period_in;
                    w_arm_nxt       = 1'b1;
                    w_dwell_cnt_nxt = '0;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = S_RAMP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.abort) begin
            w_state_nxt     = S_IDLE;
            w_pwm_en_nxt    = 1'b0;
            w_dc_nxt        = '0;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b0;
            w_arm_nxt       = 1'b0;
            w_dwell_cnt_nxt = '0;
        end
    end

    always_ff @(posedge chosen_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_counter_q  <= '0;
            r_period_reg <= '0;
            r_dc_reg     <= '0;
            r_pwm_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_tgt        <= '0;
            r_stp        <= '0;
            r_dw         <= '0;
            r_per        <= '0;
            r_arm        <= 1'b0;
            r_dwell_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_counter_q  <= bus.counter;
            r_period_reg <= w_period_nxt;
            r_dc_reg     <= w_dc_nxt;
            r_pwm_en     <= w_pwm_en_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_tgt        <= w_tgt_nxt;
            r_stp        <= w_stp_nxt;
            r_dw         <= w_dw_nxt;
            r_per        <= w_per_nxt;
            r_arm        <= w_arm_nxt;
            r_dwell_cnt  <= w_dwell_cnt_nxt;
        end
    end

    assign bus.period_reg = r_period_reg;
    assign bus.DC_reg     = r_dc_reg;
    assign bus.pwm_en     = r_pwm_en;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb/tb_pwm_ramp_sequencer.sv - scoreboard bench for pwm_ramp_sequencer
module tb_pwm_ramp_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_ramp_sequencer_if #(.W(16), .DWELL_W(8)) bus();

    pwm_ramp_sequencer #(.W(16), .DWELL_W(8)) dut (
        .chosen_clk (clk),
        .rst        (rst),
        .bus        (bus)
    );

    typedef struct {
        int per;
        int dc;
        int en;
        int busy;
        int done;
        int gap;
    } exp_t;

    exp_t q[$];
    int   assert_cnt = 0;
    int   fail_cnt   = 0;
    int   cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // main_counter stand-in: one slow tick every two clocks, counts 0..period_reg-1
    initial begin
        logic tick;
        int   c;
        tick        = 1'b0;
        bus.counter = '0;
        forever begin
            @(negedge clk);
            tick = ~tick;
            if (bus.period_reg == '0) begin
                bus.counter = '0;
            end else if (tick) begin
                c = int'(bus.counter) + 1;
                bus.counter = (c >= int'(bus.period_reg)) ? 16'd0 : 16'(c);
            end
        end
    end

    // Any change of the output tuple is one DUT event, checked against the next expectation
    initial begin
        logic [34:0] cur, prev;
        int          last;
        exp_t        e;
        prev = '1;
        last = 0;
        forever begin
            @(posedge clk);
            #1;
            cur = {bus.period_reg, bus.DC_reg, bus.pwm_en, bus.busy, bus.done};
            if (cur != prev) begin
                if (bus.pwm_en && prev[2] && (bus.DC_reg != prev[18:3])) begin
                    assert_cnt++;
                    if (bus.counter != '0) begin
                        fail_cnt++;
                        $display("FAIL boundary: DC_reg changed to %0d with counter=%0d, required counter=0",
                                 bus.DC_reg, bus.counter);
                    end
                end
                assert_cnt++;
                if (q.size() == 0) begin
                    fail_cnt++;
                    $display("FAIL unexpected_event: per=%0d dc=%0d en=%0b busy=%0b done=%0b, required no change",
                             bus.period_reg, bus.DC_reg, bus.pwm_en, bus.busy, bus.done);
                end else begin
                    e = q.pop_front();
                    if (int'(bus.period_reg) != e.per || int'(bus.DC_reg) != e.dc || int'(bus.pwm_en) != e.en ||
                        int'(bus.busy) != e.busy || int'(bus.done) != e.done) begin
                        fail_cnt++;
                        $display("FAIL tuple: got per=%0d dc=%0d en=%0b busy=%0b done=%0b, required per=%0d dc=%0d en=%0d busy=%0d done=%0d",
                                 bus.period_reg, bus.DC_reg, bus.pwm_en, bus.busy, bus.done,
                                 e.per, e.dc, e.en, e.busy, e.done);
                    end
                    if (e.gap != 0) begin
                        assert_cnt++;
                        if (cyc - last != e.gap) begin
                            fail_cnt++;
                            $display("FAIL gap: dc=%0d after %0d cycles, required %0d", bus.DC_reg, cyc - last, e.gap);
                        end
                    end
                end
                last = cyc;
                prev = cur;
            end
        end
    end

    task automatic push(input int per, input int dc, input int en, input int busy, input int done, input int gap);
        exp_t e;
        e.per = per; e.dc = dc; e.en = en; e.busy = busy; e.done = done; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic pulse(input int s, input int a, input int per, input int tgt, input int stp, input int dw);
        @(negedge clk);
        bus.period_in = 16'(per);
        bus.dc_target = 16'(tgt);
        bus.dc_step   = 16'(stp);
        bus.dwell     = 8'(dw);
        bus.start     = 1'(s);
        bus.abort     = 1'(a);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        assert_cnt++;
        if (q.size() != 0) begin
            fail_cnt++;
            $display("FAIL timeout: %0d expected events still pending after %0d cycles, required 0", q.size(), budget);
            q.delete();
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.period_in = '0;
        bus.dc_target = '0;
        bus.dc_step   = '0;
        bus.dwell     = '0;
        push(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drain(10);

        // up ramp 0,2,4,6 one period apart
        push(8, 0, 1, 1, 0, 0); push(8, 2, 1, 1, 0, 0); push(8, 4, 1, 1, 0, 16);
        push(8, 6, 1, 0, 1, 16); push(8, 6, 1, 0, 0, 1);
        pulse(1, 0, 8, 6, 2, 1);
        drain(200); quiet(20);

        // down ramp from HOLD, two periods per step
        push(8, 6, 1, 1, 0, 0); push(8, 4, 1, 1, 0, 0); push(8, 2, 1, 1, 0, 32);
        push(8, 1, 1, 0, 1, 32); push(8, 1, 1, 0, 0, 1);
        pulse(1, 0, 8, 1, 2, 2);
        drain(400); quiet(40);

        // target clamped to period
        push(8, 0, 0, 0, 0, 0);
        pulse(0, 1, 8, 1, 2, 2);
        drain(10);
        push(4, 0, 1, 1, 0, 0); push(4, 3, 1, 1, 0, 0); push(4, 4, 1, 0, 1, 8); push(4, 4, 1, 0, 0, 1);
        pulse(1, 0, 4, 9, 3, 1);
        drain(200); quiet(20);

        // dc_step=0 jumps at first wrap, dwell=0
        push(4, 0, 0, 0, 0, 0);
        pulse(0, 1, 4, 9, 3, 1);
        drain(10);
        push(8, 0, 1, 1, 0, 0); push(8, 5, 1, 0, 1, 0); push(8, 5, 1, 0, 0, 1);
        pulse(1, 0, 8, 5, 0, 0);
        drain(200); quiet(20);

        // re-start from HOLD with a new period: period swaps at first wrap, dwell=0 acts as 1
        push(8, 5, 1, 1, 0, 0); push(12, 5, 1, 1, 0, 0); push(12, 6, 1, 1, 0, 24);
        push(12, 7, 1, 0, 1, 24); push(12, 7, 1, 0, 0, 1);
        pulse(1, 0, 12, 7, 1, 0);
        drain(300); quiet(30);

        // start ignored in RAMP, abort beats a simultaneous start
        push(12, 0, 0, 0, 0, 0);
        pulse(0, 1, 12, 7, 1, 0);
        drain(10);
        push(8, 0, 1, 1, 0, 0); push(8, 1, 1, 1, 0, 0);
        pulse(1, 0, 8, 6, 1, 3);
        quiet(5);
        pulse(1, 0, 8, 2, 2, 1);
        drain(300);
        push(8, 0, 0, 0, 0, 0);
        pulse(1, 1, 8, 6, 1, 3);
        drain(10); quiet(40);
        pulse(1, 1, 8, 6, 1, 1);
        quiet(60);

        // zero target: done on the start edge
        push(8, 0, 1, 0, 1, 0); push(8, 0, 1, 0, 0, 1);
        pulse(1, 0, 8, 0, 3, 1);
        drain(20); quiet(20);

        // reset mid-ramp
        push(8, 0, 0, 0, 0, 0);
        pulse(0, 1, 8, 0, 3, 1);
        drain(10);
        push(8, 0, 1, 1, 0, 0); push(8, 2, 1, 1, 0, 0);
        pulse(1, 0, 8, 6, 2, 1);
        drain(200);
        push(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drain(10); quiet(40);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
